// File: rtl/mdom_trig_pkg.sv
// mdom_trig_pkg: shared definitions for the multi-channel mDOM trigger.
//   trig_src_e   - encoding of the trig_src output
//   trig_state_e - trigger FSM states
//   RUN_MAX      - saturation value of the per-channel over-threshold run counter
//   popcount     - number of set bits in a (zero-extended) hit vector
package mdom_trig_pkg;

    typedef enum logic [1:0] {
        TRIG_NONE = 2'd0,
        TRIG_CHAN = 2'd1,
        TRIG_EXT  = 2'd2,
        TRIG_SW   = 2'd3
    } trig_src_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_HOLDOFF = 1'b1
    } trig_state_e;

    localparam int unsigned RUN_MAX = 15;

    // Supports up to 32 channels; callers zero-extend their hit vector.
    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            n = n + 6'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/mdom_trig_chan.sv
// mdom_trig_chan: one channel of the mDOM trigger.
//   clk, rst_n        - acquisition clock, async active-low reset
//   i_adc, i_thr      - sample and threshold (unsigned compare)
//   i_gt/i_et/i_lt    - compare-mode enables, OR-ed
//   i_min_width       - samples beyond the first that must be over threshold
//   i_discr           - discriminator sub-samples for this clock
//   i_discr_pol       - 1: any bit high is active, 0: any bit low is active
//   i_thresh_en       - threshold hit contributes to o_hit
//   i_discr_en        - discr rising edge contributes to o_hit
//   o_hit             - registered hit, one clock after the sample (stage 1)
//   o_thresh_tot      - threshold condition, two clocks after the sample
//   o_discr_tot       - discr active, two clocks after the sample
module mdom_trig_chan
    import mdom_trig_pkg::*;
#(
    parameter int unsigned P_ADC_WIDTH   = 12,
    parameter int unsigned P_DISCR_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [P_ADC_WIDTH-1:0]   i_adc,
    input  logic [P_ADC_WIDTH-1:0]   i_thr,
    input  logic                     i_gt,
    input  logic                     i_et,
    input  logic                     i_lt,
    input  logic [3:0]               i_min_width,
    input  logic [P_DISCR_WIDTH-1:0] i_discr,
    input  logic                     i_discr_pol,
    input  logic                     i_thresh_en,
    input  logic                     i_discr_en,
    output logic                     o_hit,
    output logic                     o_thresh_tot,
    output logic                     o_discr_tot
);

    logic [3:0] r_run;
    logic       r_fired;
    logic       r_prev_active;
    logic       r_cond_d1;
    logic       r_active_d1;

    logic       w_cond;
    logic [3:0] w_run_nxt;
    logic [4:0] w_target;
    logic       w_thresh_hit;
    logic       w_active;
    logic       w_discr_hit;

    always_comb begin
        w_cond = (i_gt & (i_adc > i_thr)) |
                 (i_et & (i_adc == i_thr)) |
                 (i_lt & (i_adc < i_thr));

        w_run_nxt = '0;
        if (w_cond) begin
            w_run_nxt = (r_run == 4'(RUN_MAX)) ? r_run : r_run + 4'd1;
        end

        // r_fired blocks re-firing for the rest of the excursion, including
        // when min_width is lowered below the current run length.
        w_target     = {1'b0, i_min_width} + 5'd1;
        w_thresh_hit = w_cond & ~r_fired & ({1'b0, w_run_nxt} == w_target);

        w_active    = i_discr_pol ? (|i_discr) : ~(&i_discr);
        w_discr_hit = w_active & ~r_prev_active;
    end

    // Previous-condition flags reset to 1 so an input already active when
    // reset is released is not mistaken for a fresh crossing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run         <= '0;
            r_fired       <= 1'b1;
            r_prev_active <= 1'b1;
            r_cond_d1     <= 1'b0;
            r_active_d1   <= 1'b0;
            o_hit         <= 1'b0;
            o_thresh_tot  <= 1'b0;
            o_discr_tot   <= 1'b0;
        end else begin
            r_run         <= w_run_nxt;
            r_fired       <= w_cond & (r_fired | w_thresh_hit);
            r_prev_active <= w_active;
            r_cond_d1     <= w_cond;
            r_active_d1   <= w_active;
            o_hit         <= (w_thresh_hit & i_thresh_en) | (w_discr_hit & i_discr_en);
            o_thresh_tot  <= r_cond_d1;
            o_discr_tot   <= r_active_d1;
        end
    end

endmodule

// File: rtl/mdom_trigger_nch.sv
// mdom_trigger_nch: multi-channel mDOM trigger with M-of-N coincidence,
// channel/external/software arbitration and programmable holdoff.
//   clk, rst_n            - acquisition clock, async active-low reset
//   adc_in, discr_in      - packed per-channel samples (channel 0 in LSBs)
//   adc_out, discr_out    - inputs delayed 2 clk, aligned with trig
//   thr, gt, et, lt       - per-channel threshold and compare modes
//   thresh_trig_en        - per-channel threshold enable
//   discr_trig_en         - per-channel discr enable
//   discr_trig_pol        - discr active polarity
//   min_width             - extra samples over threshold required
//   coinc_m               - channel hits required (0 acts as 1)
//   holdoff               - dead clocks after a trigger
//   run                   - software trigger (rising edge)
//   ext_run, ext_trig_en  - asynchronous external trigger and its enable
//   trig, trig_src, trig_ch_mask - one-clock trigger pulse and its source
//   thresh_tot, discr_tot - per-channel conditions aligned to adc_out
//   holdoff_active        - high while in holdoff
//   n_suppressed          - saturating count of cycles with dropped requests
module mdom_trigger_nch
    import mdom_trig_pkg::*;
#(
    parameter int unsigned P_N_CH          = 4,
    parameter int unsigned P_ADC_WIDTH     = 12,
    parameter int unsigned P_DISCR_WIDTH   = 8,
    parameter int unsigned P_HOLDOFF_WIDTH = 16,
    parameter int unsigned P_CNT_WIDTH     = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [P_N_CH*P_ADC_WIDTH-1:0]     adc_in,
    input  logic [P_N_CH*P_DISCR_WIDTH-1:0]   discr_in,
    output logic [P_N_CH*P_ADC_WIDTH-1:0]     adc_out,
    output logic [P_N_CH*P_DISCR_WIDTH-1:0]   discr_out,
    input  logic [P_N_CH*P_ADC_WIDTH-1:0]     thr,
    input  logic                              gt,
    input  logic                              et,
    input  logic                              lt,
    input  logic [P_N_CH-1:0]                 thresh_trig_en,
    input  logic [P_N_CH-1:0]                 discr_trig_en,
    input  logic                              discr_trig_pol,
    input  logic [3:0]                        min_width,
    input  logic [$clog2(P_N_CH+1)-1:0]       coinc_m,
    input  logic [P_HOLDOFF_WIDTH-1:0]        holdoff,
    input  logic                              run,
    input  logic                              ext_run,
    input  logic                              ext_trig_en,
    output logic                              trig,
    output logic [1:0]                        trig_src,
    output logic [P_N_CH-1:0]                 trig_ch_mask,
    output logic [P_N_CH-1:0]                 thresh_tot,
    output logic [P_N_CH-1:0]                 discr_tot,
    output logic                              holdoff_active,
    output logic [P_CNT_WIDTH-1:0]            n_suppressed
);

    logic [P_N_CH-1:0] w_hit;

    for (genvar k = 0; k < P_N_CH; k++) begin : g_ch
        mdom_trig_chan #(
            .P_ADC_WIDTH   (P_ADC_WIDTH),
            .P_DISCR_WIDTH (P_DISCR_WIDTH)
        ) u_chan (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_adc        (adc_in[k*P_ADC_WIDTH +: P_ADC_WIDTH]),
            .i_thr        (thr[k*P_ADC_WIDTH +: P_ADC_WIDTH]),
            .i_gt         (gt),
            .i_et         (et),
            .i_lt         (lt),
            .i_min_width  (min_width),
            .i_discr      (discr_in[k*P_DISCR_WIDTH +: P_DISCR_WIDTH]),
            .i_discr_pol  (discr_trig_pol),
            .i_thresh_en  (thresh_trig_en[k]),
            .i_discr_en   (discr_trig_en[k]),
            .o_hit        (w_hit[k]),
            .o_thresh_tot (thresh_tot[k]),
            .o_discr_tot  (discr_tot[k])
        );
    end

    // Data delay line: two stages so samples line up with the trigger pulse.
    logic [P_N_CH*P_ADC_WIDTH-1:0]   r_adc_d1;
    logic [P_N_CH*P_DISCR_WIDTH-1:0] r_discr_d1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_adc_d1   <= '0;
            r_discr_d1 <= '0;
            adc_out    <= '0;
            discr_out  <= '0;
        end else begin
            r_adc_d1   <= adc_in;
            r_discr_d1 <= discr_in;
            adc_out    <= r_adc_d1;
            discr_out  <= r_discr_d1;
        end
    end

    // External trigger synchroniser plus edge detect; software edge detect.
    logic r_ext_meta;
    logic r_ext_sync;
    logic r_ext_prev;
    logic r_run_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ext_meta <= 1'b0;
            r_ext_sync <= 1'b0;
            r_ext_prev <= 1'b0;
            r_run_prev <= 1'b0;
        end else begin
            r_ext_meta <= ext_run;
            r_ext_sync <= r_ext_meta;
            r_ext_prev <= r_ext_sync;
            r_run_prev <= run;
        end
    end

    logic       w_ext_req;
    logic       w_sw_req;
    logic       w_chan_req;
    logic [5:0] w_hit_cnt;
    logic [5:0] w_need;

    always_comb begin
        w_ext_req  = r_ext_sync & ~r_ext_prev & ext_trig_en;
        w_sw_req   = run & ~r_run_prev;
        w_hit_cnt  = popcount(32'(w_hit));
        w_need     = (coinc_m == '0) ? 6'd1 : 6'(coinc_m);
        w_chan_req = (w_hit_cnt >= w_need);
    end

    // Trigger FSM with registered outputs.
    trig_state_e                r_state;
    trig_state_e                w_state_nxt;
    logic [P_HOLDOFF_WIDTH-1:0] r_hold_cnt;
    logic [P_HOLDOFF_WIDTH-1:0] w_hold_cnt_nxt;
    trig_src_e                  r_src;
    trig_src_e                  w_src_nxt;
    logic                       w_trig_nxt;
    logic [P_N_CH-1:0]          w_mask_nxt;
    logic                       w_drop;
    logic                       w_any_req;
    logic                       w_multi_req;

    always_comb begin
        w_state_nxt    = r_state;
        w_hold_cnt_nxt = r_hold_cnt;
        w_trig_nxt     = 1'b0;
        w_src_nxt      = TRIG_NONE;
        w_mask_nxt     = '0;
        w_drop         = 1'b0;
        w_any_req      = w_chan_req | w_ext_req | w_sw_req;
        w_multi_req    = (w_chan_req & (w_ext_req | w_sw_req)) | (w_ext_req & w_sw_req);

        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_trig_nxt = 1'b1;
                    w_drop     = w_multi_req;
                    if (w_chan_req) begin
                        w_src_nxt  = TRIG_CHAN;
                        w_mask_nxt = w_hit;
                    end else if (w_ext_req) begin
                        w_src_nxt = TRIG_EXT;
                    end else begin
                        w_src_nxt = TRIG_SW;
                    end
                    if (holdoff != '0) begin
                        w_state_nxt    = ST_HOLDOFF;
                        w_hold_cnt_nxt = holdoff;
                    end
                end
            end
            ST_HOLDOFF: begin
                w_drop         = w_any_req;
                w_hold_cnt_nxt = r_hold_cnt - P_HOLDOFF_WIDTH'(1);
                if (r_hold_cnt <= P_HOLDOFF_WIDTH'(1)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_hold_cnt   <= '0;
            r_src        <= TRIG_NONE;
            trig         <= 1'b0;
            trig_ch_mask <= '0;
            n_suppressed <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_hold_cnt   <= w_hold_cnt_nxt;
            r_src        <= w_src_nxt;
            trig         <= w_trig_nxt;
            trig_ch_mask <= w_mask_nxt;
            if (w_drop && (n_suppressed != '1)) begin
                n_suppressed <= n_suppressed + P_CNT_WIDTH'(1);
            end
        end
    end

    assign trig_src       = r_src;
    assign holdoff_active = (r_state == ST_HOLDOFF);

endmodule
